// File: rtl/psum_quant_drain.sv
// psum_quant_drain
//   Downstream stage of the sparse MAC array. It captures one group of four
//   signed partial-sum lanes together with a requantization shift and a ReLU
//   enable. It then drains the group one lane per cycle into an output FIFO.
//   Each lane goes through ReLU, a round-half-up arithmetic right shift and
//   saturation to a signed byte.
//
// Ports
//   Clk, rst               clock (rising edge), asynchronous active-high reset
//   In_valid / In_ready    lane-group handshake (accepted only in IDLE)
//   Input_0..Input_3       signed ACC_WIDTH partial sums
//   Shift, Relu_en         quantization controls, captured with the group
//   Out_valid / Out_ready  FIFO head handshake
//   Output_data            quantized byte at the FIFO head
//   Output_lane            lane index of the head byte
//   Output_last            head byte came from lane 3
//   Busy                   a group is draining or the FIFO holds data
//   Sat_count              count of clipped lanes, sticks at 255
module psum_quant_drain #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   Clk,
    input  logic                   rst,
    input  logic                   In_valid,
    output logic                   In_ready,
    input  logic [ACC_WIDTH-1:0]   Input_0,
    input  logic [ACC_WIDTH-1:0]   Input_1,
    input  logic [ACC_WIDTH-1:0]   Input_2,
    input  logic [ACC_WIDTH-1:0]   Input_3,
    input  logic [SHIFT_WIDTH-1:0] Shift,
    input  logic                   Relu_en,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [DATA_WIDTH-1:0]  Output_data,
    output logic [1:0]             Output_lane,
    output logic                   Output_last,
    output logic                   Busy,
    output logic [7:0]             Sat_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // One FIFO entry is {lane[1:0], last, data}.
    localparam int ENT_W = DATA_WIDTH + 3;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // Saturation bounds expressed at the widened internal precision.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        $signed({{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        $signed({{(ACC_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}});

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic [1:0]             lane_cnt_q, lane_cnt_d;
    logic [ACC_WIDTH-1:0]   lane_q [4];
    logic [ACC_WIDTH-1:0]   lane_d [4];
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   relu_q, relu_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]         count_q, count_d;
    logic [7:0]             sat_cnt_q, sat_cnt_d;
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic [ENT_W-1:0]       push_entry;
    logic [ENT_W-1:0]       head_entry;

    // ------------------------------------------------------------------
    // Quantizer for the lane currently selected by lane_cnt_q.
    // One extra bit of headroom keeps the rounding add from wrapping.
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH:0] x_ext;
    logic signed [ACC_WIDTH:0] x_relu;
    logic signed [ACC_WIDTH:0] round_add;
    logic signed [ACC_WIDTH:0] x_rnd;
    logic signed [ACC_WIDTH:0] y_val;
    logic [DATA_WIDTH-1:0]     q_byte;
    logic                      clip;

    always_comb begin
        x_ext  = $signed({lane_q[lane_cnt_q][ACC_WIDTH-1], lane_q[lane_cnt_q]});
        x_relu = (relu_q && x_ext[ACC_WIDTH]) ? '0 : x_ext;
        // (1 << shift) >> 1 is 2^(shift-1), and it is 0 for shift == 0.
        // So a zero shift passes the value through unchanged.
        round_add = $signed(({{ACC_WIDTH{1'b0}}, 1'b1} << shift_q) >> 1);
        x_rnd  = x_relu + round_add;
        y_val  = x_rnd >>> shift_q;
        clip   = 1'b0;
        if (y_val > SAT_MAX) begin
            q_byte = SAT_MAX[DATA_WIDTH-1:0];
            clip   = 1'b1;
        end else if (y_val < SAT_MIN) begin
            q_byte = SAT_MIN[DATA_WIDTH-1:0];
            clip   = 1'b1;
        end else begin
            q_byte = y_val[DATA_WIDTH-1:0];
        end
    end

    assign push_entry = {lane_cnt_q, (lane_cnt_q == 2'd3), q_byte};

    // ------------------------------------------------------------------
    // Next-state logic: FSM, capture registers, FIFO pointers, counters.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        for (int i = 0; i < 4; i++) begin
            lane_d[i] = lane_q[i];
        end
        push = 1'b0;
        pop  = (count_q != '0) && Out_ready;

        case (state_q)
            IDLE: begin
                if (In_valid) begin
                    lane_d[0]  = Input_0;
                    lane_d[1]  = Input_1;
                    lane_d[2]  = Input_2;
                    lane_d[3]  = Input_3;
                    shift_d    = Shift;
                    relu_d     = Relu_en;
                    lane_cnt_d = 2'd0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                // The full test uses the registered count. A pop in the same
                // cycle does not open a slot until the next cycle.
                if (count_q != FULL_CNT) begin
                    push       = 1'b1;
                    lane_cnt_d = 2'(lane_cnt_q + 2'd1);
                    if (lane_cnt_q == 2'd3) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);

        wr_ptr_d = push ? PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop  ? PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        sat_cnt_d = sat_cnt_q;
        if (push && clip && (sat_cnt_q != 8'hFF)) begin
            sat_cnt_d = sat_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            lane_cnt_q <= 2'd0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sat_cnt_q  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            lane_cnt_q <= lane_cnt_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sat_cnt_q  <= sat_cnt_d;
            for (int i = 0; i < 4; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    // FIFO storage has no reset. An empty FIFO never exposes a stale entry,
    // because the outputs are gated below.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head_entry  = mem_q[rd_ptr_q];
    assign Out_valid   = (count_q != '0);
    assign Output_data = Out_valid ? head_entry[DATA_WIDTH-1:0] : '0;
    assign Output_last = Out_valid ? head_entry[DATA_WIDTH] : 1'b0;
    assign Output_lane = Out_valid ? head_entry[ENT_W-1 -: 2] : 2'd0;
    assign In_ready    = in_ready_q;
    assign Busy        = (state_q == DRAIN) || Out_valid;
    assign Sat_count   = sat_cnt_q;

endmodule

// File: tb/tb_psum_quant_drain.sv
// Directed testbench for psum_quant_drain. Every expected byte is computed by
// hand from the quantization rule and is stored as {lane, last, data}.
module tb_psum_quant_drain;

    logic        Clk;
    logic        rst;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] Input_0, Input_1, Input_2, Input_3;
    logic [4:0]  Shift;
    logic        Relu_en;
    logic        Out_valid;
    logic        Out_ready;
    logic [7:0]  Output_data;
    logic [1:0]  Output_lane;
    logic        Output_last;
    logic        Busy;
    logic [7:0]  Sat_count;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [10:0] recv_q [$];
    logic [10:0] exp_q  [$];

    psum_quant_drain dut (
        .Clk(Clk), .rst(rst),
        .In_valid(In_valid), .In_ready(In_ready),
        .Input_0(Input_0), .Input_1(Input_1), .Input_2(Input_2), .Input_3(Input_3),
        .Shift(Shift), .Relu_en(Relu_en),
        .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Output_data(Output_data), .Output_lane(Output_lane),
        .Output_last(Output_last), .Busy(Busy), .Sat_count(Sat_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Record every byte that is popped at the following rising edge.
    always @(negedge Clk) begin
        if (!rst && Out_valid && Out_ready) begin
            recv_q.push_back({Output_lane, Output_last, Output_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic expect_group(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
        exp_q.push_back({2'd0, 1'b0, d0});
        exp_q.push_back({2'd1, 1'b0, d1});
        exp_q.push_back({2'd2, 1'b0, d2});
        exp_q.push_back({2'd3, 1'b1, d3});
    endtask

    // Called at posedge+1. Returns at posedge+1 after the accepting edge.
    task automatic send_group(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic [4:0] sh, input logic relu);
        int n = 0;
        while (!In_ready && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!In_ready) begin
            check("accept_timeout", {31'd0, In_ready}, 32'd1);
        end else begin
            Input_0 = a; Input_1 = b; Input_2 = c; Input_3 = d;
            Shift = sh; Relu_en = relu; In_valid = 1'b1;
            @(posedge Clk); #1;
            // Scramble the inputs so that a group that is not held in the
            // capture registers shows up as wrong bytes.
            In_valid = 1'b0;
            Input_0 = 32'hDEADBEEF; Input_1 = 32'h80000001;
            Input_2 = 32'h12345678; Input_3 = 32'hFFFF0000;
            Shift = ~sh; Relu_en = ~relu;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 300) begin
            @(posedge Clk); #1;
            n++;
        end
        check("idle_timeout", {31'd0, Busy}, 32'd0);
    endtask

    task automatic compare_out(input string tag);
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            got = (recv_q.size() > 0) ? {21'd0, recv_q.pop_front()} : 32'hFFFFFFFF;
            check(tag, got, {21'd0, exp_q.pop_front()});
        end
        check({tag, "_extra"}, recv_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b0;
        Input_0 = '0; Input_1 = '0; Input_2 = '0; Input_3 = '0;
        Shift = '0; Relu_en = 1'b0;
        #2;
        check("rst_in_ready",  {31'd0, In_ready},    32'd1);
        check("rst_out_valid", {31'd0, Out_valid},   32'd0);
        check("rst_data",      {24'd0, Output_data}, 32'd0);
        check("rst_lane",      {30'd0, Output_lane}, 32'd0);
        check("rst_last",      {31'd0, Output_last}, 32'd0);
        check("rst_busy",      {31'd0, Busy},        32'd0);
        check("rst_sat",       {24'd0, Sat_count},   32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        rst = 1'b0;

        // Group A: pass-through. Also check latency cycle by cycle.
        Out_ready = 1'b1;
        expect_group(8'h05, 8'hFD, 8'h7F, 8'h80);
        send_group(32'd5, -32'sd3, 32'd127, -32'sd128, 5'd0, 1'b0);
        check("lat_n_valid",  {31'd0, Out_valid}, 32'd0);
        check("lat_n_ready",  {31'd0, In_ready},  32'd0);
        check("lat_n_busy",   {31'd0, Busy},      32'd1);
        @(posedge Clk); #1;
        check("lat_n1_valid", {31'd0, Out_valid},   32'd1);
        check("lat_n1_data",  {24'd0, Output_data}, 32'h05);
        check("lat_n1_lane",  {30'd0, Output_lane}, 32'd0);
        @(posedge Clk); #1;
        check("lat_n2_lane",  {30'd0, Output_lane}, 32'd1);
        @(posedge Clk); #1;
        check("lat_n3_lane",  {30'd0, Output_lane}, 32'd2);
        check("lat_n3_ready", {31'd0, In_ready},    32'd0);
        @(posedge Clk); #1;
        check("lat_n4_lane",  {30'd0, Output_lane}, 32'd3);
        check("lat_n4_last",  {31'd0, Output_last}, 32'd1);
        check("lat_n4_ready", {31'd0, In_ready},    32'd1);
        wait_idle();
        compare_out("grpA");
        check("grpA_sat", {24'd0, Sat_count}, 32'd0);

        // Group B: ReLU and rounding shift by 4.
        expect_group(8'd3, 8'd0, 8'd2, 8'd1);
        send_group(32'd40, -32'sd100, 32'd24, 32'd23, 5'd4, 1'b1);
        wait_idle();
        compare_out("grpB");
        check("grpB_sat", {24'd0, Sat_count}, 32'd0);

        // Group C: every lane saturates.
        expect_group(8'h7F, 8'h80, 8'h7F, 8'h80);
        send_group(32'd1000, -32'sd1000, 32'h7FFFFFFF, 32'h80000000, 5'd0, 1'b0);
        wait_idle();
        compare_out("grpC");
        check("grpC_sat", {24'd0, Sat_count}, 32'd4);
        for (int g = 0; g < 64; g++) begin
            send_group(32'd1000, -32'sd1000, 32'h7FFFFFFF, 32'h80000000, 5'd0, 1'b0);
        end
        wait_idle();
        recv_q.delete();
        check("sat_sticky", {24'd0, Sat_count}, 32'd255);

        // Backpressure: three groups against a FIFO that holds two groups.
        Out_ready = 1'b0;
        expect_group(8'd1, 8'd2, 8'd3, 8'd4);
        expect_group(8'd5, 8'd6, 8'd7, 8'd8);
        expect_group(8'd9, 8'd10, 8'd11, 8'd12);
        send_group(32'd1, 32'd2, 32'd3, 32'd4, 5'd0, 1'b0);
        send_group(32'd5, 32'd6, 32'd7, 32'd8, 5'd0, 1'b0);
        send_group(32'd9, 32'd10, 32'd11, 32'd12, 5'd0, 1'b0);
        repeat (5) @(posedge Clk);
        #1;
        check("bp_stall_ready", {31'd0, In_ready},    32'd0);
        check("bp_stall_busy",  {31'd0, Busy},        32'd1);
        check("bp_head",        {24'd0, Output_data}, 32'd1);
        Out_ready = 1'b1;
        wait_idle();
        compare_out("bp");

        // Pop with a full FIFO: the blocked push retries, and nothing is lost.
        Out_ready = 1'b0;
        expect_group(8'd21, 8'd22, 8'd23, 8'd24);
        expect_group(8'd25, 8'd26, 8'd27, 8'd28);
        expect_group(8'd29, 8'd30, 8'd31, 8'd32);
        send_group(32'd21, 32'd22, 32'd23, 32'd24, 5'd0, 1'b0);
        send_group(32'd25, 32'd26, 32'd27, 32'd28, 5'd0, 1'b0);
        send_group(32'd29, 32'd30, 32'd31, 32'd32, 5'd0, 1'b0);
        repeat (3) @(posedge Clk);
        #1;
        Out_ready = 1'b1;
        @(posedge Clk); #1;
        Out_ready = 1'b0;
        check("full_head", {24'd0, Output_data}, 32'd22);
        repeat (3) @(posedge Clk);
        #1;
        check("full_stall_ready", {31'd0, In_ready}, 32'd0);
        Out_ready = 1'b1;
        wait_idle();
        compare_out("full");

        // Reset while a group is draining (two lanes pushed).
        Out_ready = 1'b0;
        send_group(32'd1, 32'd2, 32'd3, 32'd4, 5'd0, 1'b0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, Out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, In_ready},  32'd1);
        check("mid_rst_sat",   {24'd0, Sat_count}, 32'd0);
        check("mid_rst_busy",  {31'd0, Busy},      32'd0);
        @(posedge Clk); #1;
        rst = 1'b0;
        recv_q.delete();
        Out_ready = 1'b1;
        // Shift 1: 3->2, -3->-1, 4->2, 255->128 which clips to 127.
        expect_group(8'h02, 8'hFF, 8'h02, 8'h7F);
        send_group(32'd3, -32'sd3, 32'd4, 32'd255, 5'd1, 1'b0);
        wait_idle();
        compare_out("post_rst");
        check("post_rst_sat", {24'd0, Sat_count}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
